// File: rtl/adc_pkg.sv
// Shared types for the ADC sequencer: scan FSM states and the ADC strobe pattern of each state.
package adc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StConvst,
        StWaitEoc,
        StCs,
        StRd,
        StNext
    } adc_state_t;

    typedef struct packed {
        logic n_convst;
        logic n_cs;
        logic n_rd;
    } strobe_t;

    localparam strobe_t StrobeIdle    = 3'b111;
    localparam strobe_t StrobeSelect  = 3'b111;
    localparam strobe_t StrobeConvst  = 3'b011;
    localparam strobe_t StrobeWaitEoc = 3'b111;
    localparam strobe_t StrobeCs      = 3'b101;
    localparam strobe_t StrobeRd      = 3'b100;
    localparam strobe_t StrobeNext    = 3'b111;

    function automatic strobe_t state_strobes(adc_state_t st);
        strobe_t s;
        case (st)
            StIdle:    s = StrobeIdle;
            StSelect:  s = StrobeSelect;
            StConvst:  s = StrobeConvst;
            StWaitEoc: s = StrobeWaitEoc;
            StCs:      s = StrobeCs;
            StRd:      s = StrobeRd;
            StNext:    s = StrobeNext;
            default:   s = StrobeIdle;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/adc_sequencer_if.sv
// Parallel ADC bus: channel select, conversion/read strobes, EOC and data.
interface adc_sequencer_if #(
    parameter int unsigned CH_SEL_W = 3,
    parameter int unsigned DATA_W   = 8
);
    logic [CH_SEL_W-1:0] chnl;
    logic                n_convst;
    logic                n_cs;
    logic                n_rd;
    logic                n_eoc;
    logic [DATA_W-1:0]   adc_in;

    modport master (
        output chnl, n_convst, n_cs, n_rd,
        input  n_eoc, adc_in
    );

    modport slave (
        input  chnl, n_convst, n_cs, n_rd,
        output n_eoc, adc_in
    );
endinterface

// File: rtl/adc_tick_gen.sv
// Free-running dividers giving the FSM step enable and the frame trigger, both single-clk pulses.
module adc_tick_gen #(
    parameter int unsigned DIV_STEP  = 2,
    parameter int unsigned FRAME_DIV = 64
) (
    input  logic clk,
    input  logic n_reset,
    output logic step_en,
    output logic frame_trig
);
    localparam int unsigned StepW  = (DIV_STEP > 1) ? $clog2(DIV_STEP) : 1;
    localparam int unsigned FrameW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [StepW-1:0]  StepLast  = StepW'(DIV_STEP - 1);
    localparam logic [FrameW-1:0] FrameLast = FrameW'(FRAME_DIV - 1);

    logic [StepW-1:0]  step_cnt_q, step_cnt_d;
    logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        step_en     = (step_cnt_q == StepLast);
        frame_trig  = (frame_cnt_q == FrameLast);
        step_cnt_d  = step_en ? '0 : step_cnt_q + 1'b1;
        frame_cnt_d = frame_trig ? '0 : frame_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            step_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            step_cnt_q  <= step_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end
endmodule

// File: rtl/adc_sequencer.sv
// Scans NUM_CH channels of an EOC-signalling parallel ADC and publishes each frame atomically,
// with EOC timeout, overrun detection and run/stop control.
module adc_sequencer
    import adc_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CH_SEL_W    = 3,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DIV_STEP    = 2,
    parameter int unsigned FRAME_DIV   = 64,
    parameter int unsigned EOC_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     enable,
    input  logic                     clear_err,
    adc_sequencer_if.master          bus,
    output logic [NUM_CH*DATA_W-1:0] samples,
    output logic                     frame_valid,
    output logic                     timeout_err,
    output logic                     overrun_err
);
    localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TimW = $clog2(EOC_TIMEOUT + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CH - 1);
    localparam logic [TimW-1:0] TimLast = TimW'(EOC_TIMEOUT - 1);

    if (NUM_CH < 1 || NUM_CH > (1 << CH_SEL_W)) begin : g_bad_num_ch
        $error("adc_sequencer: NUM_CH must be within 1..2**CH_SEL_W");
    end

    logic step_en, frame_trig;

    adc_tick_gen #(
        .DIV_STEP  (DIV_STEP),
        .FRAME_DIV (FRAME_DIV)
    ) u_tick (
        .clk        (clk),
        .n_reset    (n_reset),
        .step_en    (step_en),
        .frame_trig (frame_trig)
    );

    adc_state_t                state_q, state_d;
    logic [IdxW-1:0]           ch_idx_q, ch_idx_d;
    logic [TimW-1:0]           tmo_cnt_q, tmo_cnt_d;
    logic [CH_SEL_W-1:0]       chnl_q, chnl_d;
    logic [NUM_CH*DATA_W-1:0]  shadow_q, shadow_d;
    logic [NUM_CH*DATA_W-1:0]  samples_q, samples_d;
    logic                      frame_valid_q, frame_valid_d;
    logic                      timeout_err_q, timeout_err_d;
    logic                      overrun_err_q, overrun_err_d;
    logic [1:0]                eoc_sync_q;
    logic                      eoc_seen;
    logic                      tmo_event;
    logic                      ovr_event;
    strobe_t                   strobes;

    // n_eoc is asynchronous to clk; idle level is high.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            eoc_sync_q <= 2'b11;
        end else begin
            eoc_sync_q <= {eoc_sync_q[0], bus.n_eoc};
        end
    end
    assign eoc_seen = ~eoc_sync_q[1];

    always_comb begin
        state_d       = state_q;
        ch_idx_d      = ch_idx_q;
        tmo_cnt_d     = tmo_cnt_q;
        chnl_d        = chnl_q;
        shadow_d      = shadow_q;
        samples_d     = samples_q;
        frame_valid_d = 1'b0;
        tmo_event     = 1'b0;
        ovr_event     = frame_trig && (state_q != StIdle);

        case (state_q)
            StIdle: begin
                if (frame_trig && enable) begin
                    ch_idx_d = '0;
                    state_d  = StSelect;
                end
            end
            StSelect: begin
                chnl_d = CH_SEL_W'(ch_idx_q);
                if (step_en) state_d = StConvst;
            end
            StConvst: begin
                if (step_en) begin
                    tmo_cnt_d = '0;
                    state_d   = StWaitEoc;
                end
            end
            StWaitEoc: begin
                if (step_en) begin
                    if (eoc_seen) begin
                        state_d = StCs;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                        // Abandon the channel; its shadow word keeps the previous frame's value.
                        if (tmo_cnt_q == TimLast) begin
                            tmo_event = 1'b1;
                            state_d   = StNext;
                        end
                    end
                end
            end
            StCs: begin
                if (step_en) state_d = StRd;
            end
            StRd: begin
                if (step_en) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_idx_q == IdxW'(i)) shadow_d[i*DATA_W +: DATA_W] = bus.adc_in;
                    end
                    state_d = StNext;
                end
            end
            StNext: begin
                if (step_en) begin
                    if (ch_idx_q == LastIdx) begin
                        samples_d     = shadow_q;
                        frame_valid_d = 1'b1;
                        state_d       = StIdle;
                    end else begin
                        ch_idx_d = ch_idx_q + 1'b1;
                        state_d  = StSelect;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A new error event outranks a simultaneous clear.
        timeout_err_d = tmo_event | (timeout_err_q & ~clear_err);
        overrun_err_d = ovr_event | (overrun_err_q & ~clear_err);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= StIdle;
            ch_idx_q      <= '0;
            tmo_cnt_q     <= '0;
            chnl_q        <= '0;
            shadow_q      <= '0;
            samples_q     <= '0;
            frame_valid_q <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_idx_q      <= ch_idx_d;
            tmo_cnt_q     <= tmo_cnt_d;
            chnl_q        <= chnl_d;
            shadow_q      <= shadow_d;
            samples_q     <= samples_d;
            frame_valid_q <= frame_valid_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    // Strobes decode straight from the state register so reset releases them at once.
    assign strobes      = state_strobes(state_q);
    assign bus.n_convst = strobes.n_convst;
    assign bus.n_cs     = strobes.n_cs;
    assign bus.n_rd     = strobes.n_rd;
    assign bus.chnl     = chnl_q;
    assign samples      = samples_q;
    assign frame_valid  = frame_valid_q;
    assign timeout_err  = timeout_err_q;
    assign overrun_err  = overrun_err_q;
endmodule

// File: doc/adc_sequencer.md
Name: adc_sequencer

Overview:
Parametrised successor to the 4-channel parallel-ADC sampler for the mic array. Drives a parallel-output, EOC-signalling ADC through a channel scan of NUM_CH inputs and captures one DATA_W word per channel. Publishes all channels of a frame atomically with a one-cycle frame_valid strobe. Timing comes from clock enables inside the single clk domain, not from derived clocks. Adds EOC timeout, overrun detection and run/stop control.

Parameters:
NUM_CH, 4, channels scanned per frame (1..2**CH_SEL_W)
CH_SEL_W, 3, width of ADC channel-select bus
DATA_W, 8, ADC data width
DIV_STEP, 2, clk cycles per FSM step (>=1)
FRAME_DIV, 64, clk cycles between frame triggers (>=2)
EOC_TIMEOUT, 16, FSM steps allowed in WAIT_EOC before abort (>=1)

Ports:
clk  in  1  system clock
n_reset  in  1  asynchronous active-low reset
enable  in  1  run control; sampled on frame trigger
clear_err  in  1  synchronous clear of sticky error flags
chnl  out  CH_SEL_W  ADC channel select
n_convst  out  1  start conversion (active low)
n_eoc  in  1  end of conversion from ADC (active low, treated as async: 2-flop synchronised)
n_cs  out  1  ADC chip select (active low)
n_rd  out  1  ADC read strobe (active low)
adc_in  in  DATA_W  ADC data bus
samples  out  NUM_CH*DATA_W  published frame; channel i at [i*DATA_W +: DATA_W]
frame_valid  out  1  one-clk pulse when samples updates
timeout_err  out  1  sticky: some channel hit EOC timeout
overrun_err  out  1  sticky: frame trigger arrived while busy

Behaviour:
- Reset (async assert, sync release): n_convst=n_cs=n_rd=1, chnl=0, samples=0, shadow regs=0, frame_valid=0, both errs=0, FSM=IDLE, counters=0. Reset mid-conversion releases all strobes immediately.
- step_en: 1-clk pulse every DIV_STEP clks from a free-running counter. frame_trig: 1-clk pulse every FRAME_DIV clks. Both counters wrap to 0.
- The FSM advances only on step_en, except for the IDLE exit, which happens on frame_trig.
- States and outputs {n_convst,n_cs,n_rd}:
  IDLE 111: on frame_trig with enable=1, set ch_idx=0 and go to SELECT. With enable=0, stay in IDLE.
  SELECT 111: chnl=ch_idx. Go to CONVST.
  CONVST 011: go to WAIT_EOC. Clear the timeout counter.
  WAIT_EOC 111: if synchronised n_eoc=0, go to CS. Otherwise increment the timeout counter. When it reaches EOC_TIMEOUT, set timeout_err and go to NEXT; the shadow word for that channel keeps its previous value.
  CS 101: go to RD.
  RD 100: on the step_en that leaves RD, capture adc_in into shadow[ch_idx]. Go to NEXT.
  NEXT 111: if ch_idx==NUM_CH-1, copy shadow to samples, pulse frame_valid, go to IDLE. Otherwise increment ch_idx and go to SELECT.
- chnl holds its value from SELECT through NEXT. It changes only in SELECT.
- Per-channel time is (5+k) steps, where k>=1 is the number of WAIT_EOC steps.
- Publish latency: samples and frame_valid update on the clk edge after NEXT of the last channel.
- frame_trig while not in IDLE sets overrun_err. The trigger is dropped and the current frame continues.
- enable is checked only in IDLE. Deasserting it mid-frame completes and publishes the current frame.
- clear_err=1 clears both flags that cycle. If a new error event occurs in the same cycle as clear_err, the error wins.
- ch_idx width is clog2(NUM_CH) (minimum 1). Channels >= NUM_CH are never selected. chnl is ch_idx zero-extended to CH_SEL_W.
- Elaboration fails if NUM_CH > 2**CH_SEL_W.

Decomposition:
- Package adc_pkg: state enum adc_state_t (IDLE, SELECT, CONVST, WAIT_EOC, CS, RD, NEXT) and the strobe encodings for each state as localparams.
- Sub-module adc_tick_gen: a parametrised divider producing step_en and frame_trig from clk/n_reset. It is instantiated once with both divide values.

Test Plan:
- NUM_CH=4, ADC model returns 8'h10+ch with EOC 3 steps after convst -> one frame_valid pulse; samples=32'h13121110; chnl sequence 0,1,2,3.
- Channel 2 model never asserts EOC -> after 16 WAIT_EOC steps timeout_err=1; ch2 keeps its prior value (0 after reset); ch3 is captured normally; frame still publishes.
- FRAME_DIV=32 with slow EOC (frame longer than 32 clks) -> overrun_err=1; exactly one frame_valid per completed frame; no state corruption.
- enable dropped during channel 1 -> frame completes, frame_valid pulses once, FSM stays in IDLE; re-enable -> the next frame_trig starts a scan at ch 0.
- n_reset asserted while n_rd=0 in RD -> n_rd, n_cs, n_convst go to 1 and samples go to 0 without waiting for a clk edge; the first frame after release is correct.
- clear_err pulse with both flags set -> both flags go to 0 the next cycle; a clear coincident with a new timeout leaves timeout_err=1.
